lane_collision_monitor: RTL and testbench
=========================================

// Module: lane_collision_monitor
// PURPOSE
//  Consumer of the per-car x positions produced by the car movement blocks for one lane.
//  Once per frame it snapshots the frog box and all car boxes, then scans the cars one per cycle.
//  On overlap it pulses a hit, decrements lives and enters a frame-counted invulnerability window.
//  Sits between the lane car movers / frog controller and the game-state / VGA overlay logic.
// PARAMETERS
//  N_CARS          4    cars in the lane (1..8)
//  LANE_Y          200  lane top row, pixels
//  CAR_W           32   car width, pixels
//  CAR_H           16   car height, pixels
//  FROG_W          16   frog width, pixels
//  FROG_H          16   frog height, pixels
//  START_LIVES     3    lives after reset/restart (1..15)
//  COOLDOWN_FRAMES 60   invulnerable frames after a hit (1..255)
// PORTS
//  i_Clk           in   1          system clock
//  i_Rst_L         in   1          async active-low reset
//  i_Frame_Start   in   1          1-cycle strobe, start of vertical blank
//  i_Car_X         in   10*N_CARS  packed car x; car k = [10k+9:10k]
//  i_Frog_X        in   10         frog left column
//  i_Frog_Y        in   10         frog top row
//  i_Restart       in   1          synchronous restart request (level, sampled each clk)
//  o_Hit           out  1          1-cycle pulse per registered collision
//  o_Lives         out  4          remaining lives
//  o_Invulnerable  out  1          high while in COOLDOWN
//  o_Game_Over     out  1          high while in GAME_OVER
//  o_Busy          out  1          high while in CHECK
// BEHAVIOUR
//  Reset (async, i_Rst_L=0): state=ARMED, o_Lives=START_LIVES, o_Hit=0, o_Invulnerable=0,
//   o_Game_Over=0, o_Busy=0, car index=0, cooldown count=0, snapshot regs=0.
//  States: ARMED, CHECK, HIT, COOLDOWN, GAME_OVER.
//  ARMED: on i_Frame_Start, latch i_Car_X, i_Frog_X, i_Frog_Y into snapshot; index=0; -> CHECK.
//  CHECK: one car per cycle, index 0..N_CARS-1, using snapshot only (live inputs ignored).
//   overlap(k) = Fx < Cx+CAR_W && Cx < Fx+FROG_W && Fy < LANE_Y+CAR_H && LANE_Y < Fy+FROG_H,
//   all sums in 11-bit unsigned (no overflow); no horizontal wrap, cars clipped at edge.
//   First overlap -> HIT next cycle (remaining cars skipped).
//   No overlap at index N_CARS-1 -> ARMED. Scan length = N_CARS cycles max.
//  HIT (one cycle): o_Hit=1; o_Lives-=1. If o_Lives was 1 -> GAME_OVER, else cooldown=
//   COOLDOWN_FRAMES, -> COOLDOWN. o_Lives never underflows below 0.
//  COOLDOWN: o_Invulnerable=1; each i_Frame_Start decrements cooldown; when it reaches 0
//   -> ARMED the next cycle (frame strobe that zeroes it does not start a check).
//  GAME_OVER: o_Game_Over=1, o_Lives=0; i_Frame_Start ignored; leave only via i_Restart.
//  i_Frame_Start during CHECK or HIT: ignored (not queued).
//  i_Restart=1 in any state: next cycle state=ARMED, o_Lives=START_LIVES, cooldown=0,
//   o_Hit=0; restart has priority over a same-cycle i_Frame_Start or hit.
//  All outputs registered; o_Hit appears 2..N_CARS+1 cycles after the frame strobe.
//  Reset mid-scan or mid-cooldown aborts immediately; no hit is reported.
// TESTING
//  1 Reset, N_CARS=4, frog (100,200), cars {0,300,500,600}, frame strobe -> o_Busy 4 cycles,
//    no o_Hit, o_Lives=3, back to ARMED.
//  2 Car2 x=90, frog x=100,y=200, strobe -> o_Hit one pulse 4 cycles after strobe
//    (index 2), o_Lives=2, o_Invulnerable=1.
//  3 Edges: car x=84 (84+32=116, frog 100..115) -> hit; car x=116 -> no hit;
//    frog y=216 -> no hit; frog y=185 -> hit.
//  4 In COOLDOWN with overlap held: 59 strobes -> no hit, still invulnerable;
//    60th -> ARMED; 61st -> hit.
//  5 Three hits from START_LIVES=3 -> o_Lives=0, o_Game_Over=1; further strobes no hit;
//    i_Restart same cycle as strobe -> ARMED, o_Lives=3, no check that frame.
//  6 i_Rst_L low during CHECK with overlapping car pending -> no o_Hit, all outputs at reset values.
//    Live i_Car_X changed during CHECK -> result uses snapshot.

Source files
------------

// File: rtl/lane_collision_monitor.sv
// Lane collision monitor: snapshots frog and car boxes once per frame,
// scans cars one per cycle, and tracks lives plus invulnerability frames.
module lane_collision_monitor #(
    parameter int N_CARS          = 4,
    parameter int LANE_Y          = 200,
    parameter int CAR_W           = 32,
    parameter int CAR_H           = 16,
    parameter int FROG_W          = 16,
    parameter int FROG_H          = 16,
    parameter int START_LIVES     = 3,
    parameter int COOLDOWN_FRAMES = 60
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Frame_Start,
    input  logic [10*N_CARS-1:0] i_Car_X,
    input  logic [9:0]           i_Frog_X,
    input  logic [9:0]           i_Frog_Y,
    input  logic                 i_Restart,
    output logic                 o_Hit,
    output logic [3:0]           o_Lives,
    output logic                 o_Invulnerable,
    output logic                 o_Game_Over,
    output logic                 o_Busy
);

    localparam int IW = (N_CARS > 1) ? $clog2(N_CARS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_CARS - 1);
    localparam logic [3:0]    LIVES0   = 4'(START_LIVES);
    localparam logic [7:0]    COOL0    = 8'(COOLDOWN_FRAMES);

    typedef enum logic [2:0] {
        ARMED,
        CHECK,
        HIT,
        COOLDOWN,
        GAME_OVER
    } state_t;

    state_t        state_q;
    logic [9:0]    car_q [N_CARS];
    logic [9:0]    frog_x_q;
    logic [9:0]    frog_y_q;
    logic [IW-1:0] idx_q;
    logic [7:0]    cool_q;
    logic [3:0]    lives_q;
    logic          hit_q;
    logic          inv_q;
    logic          go_q;
    logic          busy_q;

    logic [10:0]   car_d;
    logic [10:0]   fx_d;
    logic [10:0]   fy_d;
    logic          ovl_d;

    // Box overlap of the snapshot frog against the car under scan
    always_comb begin
        car_d = {1'b0, car_q[idx_q]};
        fx_d  = {1'b0, frog_x_q};
        fy_d  = {1'b0, frog_y_q};
        ovl_d = (fx_d < car_d + 11'(CAR_W))
             && (car_d < fx_d + 11'(FROG_W))
             && (fy_d < 11'(LANE_Y + CAR_H))
             && (11'(LANE_Y) < fy_d + 11'(FROG_H));
    end

    // Game FSM with registered outputs; restart outranks every state
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= ARMED;
            for (int k = 0; k < N_CARS; k++) car_q[k] <= '0;
            frog_x_q <= '0;
            frog_y_q <= '0;
            idx_q    <= '0;
            cool_q   <= '0;
            lives_q  <= LIVES0;
            hit_q    <= 1'b0;
            inv_q    <= 1'b0;
            go_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else if (i_Restart) begin
            state_q <= ARMED;
            idx_q   <= '0;
            cool_q  <= '0;
            lives_q <= LIVES0;
            hit_q   <= 1'b0;
            inv_q   <= 1'b0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (i_Frame_Start) begin
                        for (int k = 0; k < N_CARS; k++)
                            car_q[k] <= i_Car_X[10*k +: 10];
                        frog_x_q <= i_Frog_X;
                        frog_y_q <= i_Frog_Y;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CHECK;
                    end
                end
                CHECK: begin
                    if (ovl_d) begin
                        hit_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        lives_q <= (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
                        state_q <= HIT;
                    end else if (idx_q == LAST_IDX) begin
                        busy_q  <= 1'b0;
                        state_q <= ARMED;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                HIT: begin
                    hit_q <= 1'b0;
                    if (lives_q == 4'd0) begin
                        go_q    <= 1'b1;
                        state_q <= GAME_OVER;
                    end else begin
                        cool_q  <= COOL0;
                        inv_q   <= 1'b1;
                        state_q <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (cool_q == 8'd0) begin
                        inv_q   <= 1'b0;
                        state_q <= ARMED;
                    end else if (i_Frame_Start) begin
                        cool_q <= cool_q - 8'd1;
                    end
                end
                GAME_OVER: begin
                    lives_q <= 4'd0;
                    go_q    <= 1'b1;
                end
                default: state_q <= ARMED;
            endcase
        end
    end

    assign o_Hit          = hit_q;
    assign o_Lives        = lives_q;
    assign o_Invulnerable = inv_q;
    assign o_Game_Over    = go_q;
    assign o_Busy         = busy_q;

endmodule

// File: tb/tb_lane_collision_monitor.sv
// Directed bench for lane_collision_monitor: scan timing, box edges,
// cooldown, game over, restart priority, async reset and snapshotting.
module tb_lane_collision_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fs;
    logic        restart;
    logic [39:0] car_x;
    logic [9:0]  frog_x;
    logic [9:0]  frog_y;
    logic        o_Hit;
    logic [3:0]  o_Lives;
    logic        o_Invulnerable;
    logic        o_Game_Over;
    logic        o_Busy;

    int checks = 0;
    int errors = 0;

    lane_collision_monitor dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_Frame_Start  (fs),
        .i_Car_X        (car_x),
        .i_Frog_X       (frog_x),
        .i_Frog_Y       (frog_y),
        .i_Restart      (restart),
        .o_Hit          (o_Hit),
        .o_Lives        (o_Lives),
        .o_Invulnerable (o_Invulnerable),
        .o_Game_Over    (o_Game_Over),
        .o_Busy         (o_Busy)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] pack(input logic [9:0] c0, input logic [9:0] c1,
                                         input logic [9:0] c2, input logic [9:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart;
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    // One strobe followed by 8 observed cycles; optionally alter live cars mid-scan
    task automatic frame(input logic [39:0] after, input bit use_after,
                         output int hit_at, output int nhits, output int nbusy);
        hit_at = -1;
        nhits  = 0;
        nbusy  = 0;
        fs = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 1) begin
                fs = 1'b0;
                if (use_after) car_x = after;
            end
            if (o_Busy) nbusy++;
            if (o_Hit) begin
                nhits++;
                if (hit_at < 0) hit_at = t;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (o_Lives !== 4'd3) begin
            errors++; $display("FAIL reset_lives got %0d exp 3", o_Lives);
        end
        checks++;
        if ({o_Hit, o_Invulnerable, o_Game_Over, o_Busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000",
                     {o_Hit, o_Invulnerable, o_Game_Over, o_Busy});
        end
    endtask

    task automatic test_no_hit;
        int h, n, b;
        car_x  = pack(10'd0, 10'd300, 10'd500, 10'd600);
        frog_x = 10'd100;
        frog_y = 10'd200;
        frame('0, 1'b0, h, n, b);
        checks++;
        if (b != 4) begin errors++; $display("FAIL nohit_busy got %0d exp 4", b); end
        checks++;
        if (n != 0) begin errors++; $display("FAIL nohit_hits got %0d exp 0", n); end
        checks++;
        if (o_Lives !== 4'd3 || o_Busy !== 1'b0 || o_Invulnerable !== 1'b0) begin
            errors++;
            $display("FAIL nohit_end got lives=%0d busy=%b inv=%b exp 3 0 0",
                     o_Lives, o_Busy, o_Invulnerable);
        end
    endtask

    task automatic test_hit_car2;
        int h, n, b;
        car_x = pack(10'd0, 10'd300, 10'd90, 10'd600);
        frame('0, 1'b0, h, n, b);
        checks++;
        if (h != 4) begin errors++; $display("FAIL car2_latency got %0d exp 4", h); end
        checks++;
        if (n != 1) begin errors++; $display("FAIL car2_pulses got %0d exp 1", n); end
        checks++;
        if (b != 3) begin errors++; $display("FAIL car2_busy got %0d exp 3", b); end
        checks++;
        if (o_Lives !== 4'd2 || o_Invulnerable !== 1'b1) begin
            errors++;
            $display("FAIL car2_after got lives=%0d inv=%b exp 2 1", o_Lives, o_Invulnerable);
        end
    endtask

    task automatic test_edges;
        int h, n, b;
        logic [9:0] cx [4];
        logic [9:0] fyv [4];
        int exp_n [4];
        cx[0] = 10'd84;  fyv[0] = 10'd200; exp_n[0] = 1;
        cx[1] = 10'd116; fyv[1] = 10'd200; exp_n[1] = 0;
        cx[2] = 10'd90;  fyv[2] = 10'd216; exp_n[2] = 0;
        cx[3] = 10'd90;  fyv[3] = 10'd185; exp_n[3] = 1;
        for (int i = 0; i < 4; i++) begin
            do_restart();
            frog_x = 10'd100;
            frog_y = fyv[i];
            car_x  = pack(cx[i], 10'd600, 10'd600, 10'd600);
            frame('0, 1'b0, h, n, b);
            checks++;
            if (n != exp_n[i]) begin
                errors++;
                $display("FAIL edge%0d_hits got %0d exp %0d", i, n, exp_n[i]);
            end
            if (exp_n[i] == 1) begin
                checks++;
                if (h != 2) begin
                    errors++; $display("FAIL edge%0d_latency got %0d exp 2", i, h);
                end
            end
        end
        frog_y = 10'd200;
    endtask

    task automatic test_cooldown;
        int h, n, b, tot;
        do_restart();
        car_x = pack(10'd90, 10'd600, 10'd600, 10'd600);
        frame('0, 1'b0, h, n, b);
        checks++;
        if (n != 1) begin errors++; $display("FAIL cool_first_hit got %0d exp 1", n); end
        tot = 0;
        for (int f = 0; f < 59; f++) begin
            frame('0, 1'b0, h, n, b);
            tot += n;
        end
        checks++;
        if (tot != 0 || o_Invulnerable !== 1'b1) begin
            errors++;
            $display("FAIL cool_59 got hits=%0d inv=%b exp 0 1", tot, o_Invulnerable);
        end
        frame('0, 1'b0, h, n, b);
        checks++;
        if (n != 0 || o_Invulnerable !== 1'b0) begin
            errors++;
            $display("FAIL cool_60 got hits=%0d inv=%b exp 0 0", n, o_Invulnerable);
        end
        frame('0, 1'b0, h, n, b);
        checks++;
        if (n != 1 || h != 2 || o_Lives !== 4'd1) begin
            errors++;
            $display("FAIL cool_61 got hits=%0d at=%0d lives=%0d exp 1 2 1", n, h, o_Lives);
        end
    endtask

    task automatic test_game_over;
        int h, n, b, tot;
        do_restart();
        car_x = pack(10'd90, 10'd600, 10'd600, 10'd600);
        tot = 0;
        for (int k = 0; k < 3; k++) begin
            frame('0, 1'b0, h, n, b);
            tot += n;
            if (k < 2) begin
                for (int f = 0; f < 60; f++) begin
                    frame('0, 1'b0, h, n, b);
                    tot += n;
                end
            end
        end
        checks++;
        if (tot != 3) begin errors++; $display("FAIL go_hits got %0d exp 3", tot); end
        checks++;
        if (o_Lives !== 4'd0 || o_Game_Over !== 1'b1) begin
            errors++;
            $display("FAIL go_state got lives=%0d go=%b exp 0 1", o_Lives, o_Game_Over);
        end
        frame('0, 1'b0, h, n, b);
        checks++;
        if (n != 0 || b != 0 || o_Lives !== 4'd0) begin
            errors++;
            $display("FAIL go_ignore got hits=%0d busy=%0d lives=%0d exp 0 0 0", n, b, o_Lives);
        end
        fs = 1'b1;
        restart = 1'b1;
        tick();
        fs = 1'b0;
        restart = 1'b0;
        checks++;
        if (o_Lives !== 4'd3 || o_Game_Over !== 1'b0 || o_Busy !== 1'b0) begin
            errors++;
            $display("FAIL go_restart got lives=%0d go=%b busy=%b exp 3 0 0",
                     o_Lives, o_Game_Over, o_Busy);
        end
        tot = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (o_Hit || o_Busy) tot++;
        end
        checks++;
        if (tot != 0) begin errors++; $display("FAIL go_nocheck got %0d exp 0", tot); end
    endtask

    task automatic test_reset_midscan;
        int tot;
        do_restart();
        car_x = pack(10'd600, 10'd600, 10'd600, 10'd90);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        tick();
        checks++;
        if (o_Busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", o_Busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_Hit, o_Invulnerable, o_Game_Over, o_Busy} !== 4'b0000 || o_Lives !== 4'd3) begin
            errors++;
            $display("FAIL mid_reset got flags=%b lives=%0d exp 0000 3",
                     {o_Hit, o_Invulnerable, o_Game_Over, o_Busy}, o_Lives);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tot = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (o_Hit) tot++;
        end
        checks++;
        if (tot != 0) begin errors++; $display("FAIL mid_nohit got %0d exp 0", tot); end
    endtask

    task automatic test_snapshot;
        int h, n, b;
        do_restart();
        car_x = pack(10'd90, 10'd600, 10'd600, 10'd600);
        frame(pack(10'd600, 10'd600, 10'd600, 10'd600), 1'b1, h, n, b);
        checks++;
        if (n != 1 || h != 2) begin
            errors++; $display("FAIL snap_keep got hits=%0d at=%0d exp 1 2", n, h);
        end
        do_restart();
        car_x = pack(10'd600, 10'd600, 10'd600, 10'd600);
        frame(pack(10'd90, 10'd90, 10'd90, 10'd90), 1'b1, h, n, b);
        checks++;
        if (n != 0 || b != 4) begin
            errors++; $display("FAIL snap_ignore got hits=%0d busy=%0d exp 0 4", n, b);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        fs      = 1'b0;
        restart = 1'b0;
        car_x   = pack(10'd0, 10'd300, 10'd500, 10'd600);
        frog_x  = 10'd100;
        frog_y  = 10'd200;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_no_hit();
        test_hit_car2();
        test_edges();
        test_cooldown();
        test_game_over();
        test_reset_midscan();
        test_snapshot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
